// File: rtl/mmio64_csr_responder.sv
// AFU-side MMIO64 CSR responder: fixed-latency pipelined reads, single-cycle writes,
// device feature header, AFU ID, scratch, control, status and error-cause registers.
module mmio64_csr_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_1001,
    parameter logic [63:0] AFU_ID_L   = 64'h0,
    parameter logic [63:0] AFU_ID_H   = 64'h0,
    parameter int          RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] mmio_address,
    input  logic                  mmio_read,
    input  logic                  mmio_write,
    input  logic [63:0]           mmio_writedata,
    input  logic [7:0]            mmio_byteenable,
    input  logic                  mmio_burstcount,
    output logic                  mmio_waitrequest,
    output logic [63:0]           mmio_readdata,
    output logic                  mmio_readdatavalid,
    input  logic [31:0]           kernel_status,
    input  logic [7:0]            err_event,
    output logic                  ctrl_start,
    output logic                  ctrl_soft_reset,
    output logic                  irq_pending
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_DFH      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_AFU_ID_L = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_AFU_ID_H = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS   = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ERR      = ADDR_WIDTH'(7);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ERR_MASK = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RD_COUNT = ADDR_WIDTH'(9);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WARM,
        ST_RUN
    } start_state_t;

    start_state_t state;

    logic [63:0] scratch;
    logic [7:0]  err_cause;
    logic [7:0]  err_mask;
    logic [31:0] read_count;
    logic [63:0] rd_mux;
    logic [7:0]  err_w1c;
    logic        rd_acc;
    logic        wr_acc;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [63:0]           pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] in_vld;
    logic [63:0]           in_data   [RD_LATENCY];

    // Every access is single-beat, so the burst count carries no information.
    logic unused_burstcount;
    assign unused_burstcount = mmio_burstcount;

    assign rd_acc  = mmio_read  && !mmio_waitrequest;
    assign wr_acc  = mmio_write && !mmio_waitrequest;
    assign err_w1c = (wr_acc && mmio_address == ADDR_ERR && mmio_byteenable[0])
                     ? mmio_writedata[7:0] : 8'h0;

    // Waitrequest is held for one extra cycle after reset, then never again.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_RESET;
            mmio_waitrequest <= 1'b1;
        end else begin
            case (state)
                ST_RESET: state <= ST_WARM;
                ST_WARM: begin
                    state            <= ST_RUN;
                    mmio_waitrequest <= 1'b0;
                end
                default: mmio_waitrequest <= 1'b0;
            endcase
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns rd_mux and no latch is inferred.
        rd_mux = '0;
        case (mmio_address)
            ADDR_DFH:      rd_mux = DFH_VALUE;
            ADDR_AFU_ID_L: rd_mux = AFU_ID_L;
            ADDR_AFU_ID_H: rd_mux = AFU_ID_H;
            ADDR_SCRATCH:  rd_mux = scratch;
            ADDR_CONTROL:  rd_mux = {62'h0, ctrl_soft_reset, 1'b0};
            ADDR_STATUS:   rd_mux = {32'h0, kernel_status};
            ADDR_ERR:      rd_mux = {56'h0, err_cause};
            ADDR_ERR_MASK: rd_mux = {56'h0, err_mask};
            ADDR_RD_COUNT: rd_mux = {32'h0, read_count};
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scratch         <= '0;
            ctrl_start      <= 1'b0;
            ctrl_soft_reset <= 1'b0;
            err_cause       <= '0;
            err_mask        <= 8'hFF;
            irq_pending     <= 1'b0;
            read_count      <= '0;
        end else begin
            // NOTE: non-blocking updates mean a same-cycle read still sees pre-write state.
            ctrl_start <= wr_acc && mmio_address == ADDR_CONTROL
                          && mmio_byteenable[0] && mmio_writedata[0];
            if (wr_acc && mmio_address == ADDR_CONTROL && mmio_byteenable[0])
                ctrl_soft_reset <= mmio_writedata[1];
            if (wr_acc && mmio_address == ADDR_SCRATCH) begin
                for (int b = 0; b < 8; b++)
                    if (mmio_byteenable[b])
                        scratch[8*b +: 8] <= mmio_writedata[8*b +: 8];
            end
            if (wr_acc && mmio_address == ADDR_ERR_MASK && mmio_byteenable[0])
                err_mask <= mmio_writedata[7:0];
            // A new event outranks a clear of the same bit.
            err_cause   <= (err_cause & ~err_w1c) | err_event;
            irq_pending <= |(err_cause & ~err_mask);
            if (rd_acc)
                read_count <= read_count + 32'd1;
        end
    end

    always_comb begin
        in_vld     = '0;
        in_data    = '{default: '0};
        in_vld[0]  = rd_acc;
        in_data[0] = rd_mux;
        for (int i = 1; i < RD_LATENCY; i++) begin
            in_vld[i]  = pipe_vld[i-1];
            in_data[i] = pipe_data[i-1];
        end
    end

    // The last stage is the output register; it only loads on a valid beat so readdata holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            // NOTE: data stages are reset too because readdata must read 0 out of reset.
            for (int i = 0; i < RD_LATENCY; i++)
                pipe_data[i] <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= in_vld[i];
                if (i < RD_LATENCY - 1 || in_vld[i])
                    pipe_data[i] <= in_data[i];
            end
        end
    end

    assign mmio_readdatavalid = pipe_vld[RD_LATENCY-1];
    assign mmio_readdata      = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_mmio64_csr_responder.sv
// Directed bench for mmio64_csr_responder: hand-computed register and timing expectations.
module tb_mmio64_csr_responder;

    localparam int          RD_LATENCY = 2;
    localparam logic [63:0] DFH        = 64'h1000_0000_0000_1001;
    localparam logic [63:0] ID_L       = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H       = 64'hFEDC_BA98_7654_3210;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mmio_address = '0;
    logic        mmio_read = 1'b0;
    logic        mmio_write = 1'b0;
    logic [63:0] mmio_writedata = '0;
    logic [7:0]  mmio_byteenable = '0;
    logic        mmio_burstcount = 1'b1;
    logic        mmio_waitrequest;
    logic [63:0] mmio_readdata;
    logic        mmio_readdatavalid;
    logic [31:0] kernel_status = '0;
    logic [7:0]  err_event = '0;
    logic        ctrl_start;
    logic        ctrl_soft_reset;
    logic        irq_pending;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        string       tag;
        logic [63:0] data;
        int          cyc;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    mmio64_csr_responder #(
        .ADDR_WIDTH (16),
        .DFH_VALUE  (DFH),
        .AFU_ID_L   (ID_L),
        .AFU_ID_H   (ID_H),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mmio_address       (mmio_address),
        .mmio_read          (mmio_read),
        .mmio_write         (mmio_write),
        .mmio_writedata     (mmio_writedata),
        .mmio_byteenable    (mmio_byteenable),
        .mmio_burstcount    (mmio_burstcount),
        .mmio_waitrequest   (mmio_waitrequest),
        .mmio_readdata      (mmio_readdata),
        .mmio_readdatavalid (mmio_readdatavalid),
        .kernel_status      (kernel_status),
        .err_event          (err_event),
        .ctrl_start         (ctrl_start),
        .ctrl_soft_reset    (ctrl_soft_reset),
        .irq_pending        (irq_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responses are matched in order; the latency check pins the exact return cycle.
    always @(negedge clk) begin
        rd_exp_t e;
        if (mmio_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rdv_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_data"}, mmio_readdata, e.data);
                check({e.tag, "_lat"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic mmio_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        mmio_write      = 1'b1;
        mmio_address    = a;
        mmio_writedata  = d;
        mmio_byteenable = be;
        @(negedge clk);
        mmio_write      = 1'b0;
        mmio_byteenable = '0;
    endtask

    task automatic mmio_rd(input string tag, input logic [15:0] a, input logic [63:0] exp);
        mmio_read    = 1'b1;
        mmio_address = a;
        exp_q.push_back('{tag, exp, cyc + RD_LATENCY});
        @(negedge clk);
        mmio_read = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and waitrequest release.
        repeat (3) @(negedge clk);
        check("rst_waitreq", 64'(mmio_waitrequest), 64'd1);
        check("rst_rdv", 64'(mmio_readdatavalid), 64'd0);
        check("rst_rdata", mmio_readdata, 64'h0);
        check("rst_start", 64'(ctrl_start), 64'd0);
        check("rst_soft", 64'(ctrl_soft_reset), 64'd0);
        check("rst_irq", 64'(irq_pending), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("warm_waitreq", 64'(mmio_waitrequest), 64'd1);
        @(negedge clk);
        check("run_waitreq", 64'(mmio_waitrequest), 64'd0);
        mmio_rd("dfh", 16'd0, DFH);
        drain();

        // Scratch byte lanes, then the back-to-back read burst.
        reset_dut();
        mmio_wr(16'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        mmio_wr(16'd4, 64'h0, 8'h0F);
        mmio_wr(16'd4, 64'h0, 8'h00);
        mmio_rd("burst_id_l", 16'd1, ID_L);
        mmio_rd("burst_id_h", 16'd2, ID_H);
        mmio_rd("burst_scratch", 16'd4, 64'hFFFF_FFFF_0000_0000);
        mmio_rd("burst_rdcount", 16'd9, 64'd3);
        mmio_rd("burst_rsvd", 16'd3, 64'h0);
        drain();
        mmio_rd("scratch", 16'd4, 64'hFFFF_FFFF_0000_0000);
        drain();
        repeat (2) @(negedge clk);
        check("hold_rdv", 64'(mmio_readdatavalid), 64'd0);
        check("hold_rdata", mmio_readdata, 64'hFFFF_FFFF_0000_0000);

        // Same-cycle read and write: read sees the old value.
        mmio_read       = 1'b1;
        mmio_write      = 1'b1;
        mmio_address    = 16'd4;
        mmio_writedata  = 64'hA5A5_A5A5_A5A5_A5A5;
        mmio_byteenable = 8'hFF;
        exp_q.push_back('{"rw_same_old", 64'hFFFF_FFFF_0000_0000, cyc + RD_LATENCY});
        @(negedge clk);
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
        mmio_rd("rw_same_new", 16'd4, 64'hA5A5_A5A5_A5A5_A5A5);
        mmio_wr(16'd4, 64'h1122_3344_5566_7788, 8'h81);
        mmio_burstcount = 1'b0;
        mmio_rd("scratch_be81", 16'd4, 64'h11A5_A5A5_A5A5_A588);
        mmio_burstcount = 1'b1;
        mmio_rd("unmapped", 16'h0123, 64'h0);
        drain();

        // Control: start pulse, soft reset level, back-to-back starts.
        mmio_wr(16'd5, 64'h3, 8'h01);
        check("start_pulse", 64'(ctrl_start), 64'd1);
        check("soft_set", 64'(ctrl_soft_reset), 64'd1);
        @(negedge clk);
        check("start_clear", 64'(ctrl_start), 64'd0);
        mmio_rd("control_rb", 16'd5, 64'h2);
        drain();
        mmio_wr(16'd5, 64'h1, 8'h01);
        check("start_b2b_0", 64'(ctrl_start), 64'd1);
        mmio_wr(16'd5, 64'h1, 8'h01);
        check("start_b2b_1", 64'(ctrl_start), 64'd1);
        @(negedge clk);
        check("start_b2b_end", 64'(ctrl_start), 64'd0);
        check("soft_clear", 64'(ctrl_soft_reset), 64'd0);

        // Status is captured at accept.
        kernel_status = 32'hDEAD_BEEF;
        mmio_rd("status", 16'd6, 64'h0000_0000_DEAD_BEEF);
        kernel_status = 32'h1234_5678;
        drain();

        // Error causes, mask, W1C and irq lag.
        mmio_wr(16'd8, 64'hFE, 8'h01);
        err_event = 8'h05;
        @(negedge clk);
        err_event = 8'h00;
        check("irq_lag", 64'(irq_pending), 64'd0);
        @(negedge clk);
        check("irq_set", 64'(irq_pending), 64'd1);
        mmio_rd("err_cause", 16'd7, 64'h05);
        drain();
        err_event = 8'h01;
        mmio_wr(16'd7, 64'h01, 8'h01);
        err_event = 8'h00;
        mmio_rd("err_set_wins", 16'd7, 64'h05);
        drain();
        mmio_wr(16'd7, 64'h05, 8'h01);
        check("irq_clr_lag", 64'(irq_pending), 64'd1);
        @(negedge clk);
        check("irq_clr", 64'(irq_pending), 64'd0);
        err_event = 8'h02;
        @(negedge clk);
        err_event = 8'h00;
        repeat (2) @(negedge clk);
        check("irq_masked", 64'(irq_pending), 64'd0);
        mmio_rd("err_masked", 16'd7, 64'h02);
        drain();

        // Reset with a read in flight: response is dropped, registers restored.
        mmio_wr(16'd5, 64'h2, 8'h01);
        mmio_read    = 1'b1;
        mmio_address = 16'd4;
        @(negedge clk);
        mmio_read = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_rdv", 64'(mmio_readdatavalid), 64'd0);
        check("mid_rst_rdata", mmio_readdata, 64'h0);
        check("mid_rst_waitreq", 64'(mmio_waitrequest), 64'd1);
        check("mid_rst_soft", 64'(ctrl_soft_reset), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_rdv", 64'(mmio_readdatavalid), 64'd0);
        mmio_rd("post_scratch", 16'd4, 64'h0);
        mmio_rd("post_mask", 16'd8, 64'hFF);
        mmio_rd("post_control", 16'd5, 64'h0);
        mmio_rd("post_cause", 16'd7, 64'h0);
        mmio_rd("post_rdcount", 16'd9, 64'd4);
        drain();
        check("post_irq", 64'(irq_pending), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
